traffic_phase_scheduler: RTL and testbench
==========================================

# traffic_phase_scheduler

Sequences the two-road intersection through its light phases and arbitrates pedestrian crossing requests from both roads into a shared all-red walk phase. It generates its own 1 Hz-class tick from `clk` and owns phase timing, test-mode shortening and standby. It drives the per-road lamp enables and a seconds countdown consumed by the FND display multiplexer.

## Interface
- TICK_DIV, 1000000: `clk` cycles per phase-timing tick (1 s at 1 MHz); legal 2..2^24
- RG_TIME, 10: ticks in RG
- RY_TIME, 3: ticks in RY
- GR_TIME, 15: ticks in GR
- YR_TIME, 3: ticks in YR
- WALK_TIME, 8: ticks in WK
- TEST_TIME, 2: ticks in any timed phase when test mode is latched
- All *_TIME legal 1..31
- clk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- standby  in  1  synchronous, active-high; forces YY
- test  in  1  shortened timing, sampled at phase entry
- ped_req  in  2  pedestrian request, bit0 road 1, bit1 road 2; level, any length ≥1 cycle
- ped_ack  out  2  one-cycle pulse per request served, on WK entry
- state  out  3  YY=000 RY=001 GR=010 YR=011 RG=100 WK=101
- lamp1  out  3  road 1 {R,Y,G}, one-hot
- lamp2  out  3  road 2 {R,Y,G}, one-hot
- walk  out  1  walk lamp, high only in WK
- remaining  out  5  ticks left in current phase, including current
- tick  out  1  one-cycle timing tick
- phase_start  out  1  one-cycle pulse on the first cycle of each new phase

## Operation
- Divider: `div_cnt` counts 0..TICK_DIV-1 and wraps; `tick` is high on the cycle `div_cnt`==TICK_DIV-1. It runs freely, including in standby.
- Phase ring: RY→GR→YR→(WK if pending)→RG→RY→(WK if pending)→GR.
- YY is entered on reset or standby. YY→RY on the first tick with standby low.
- Duration: on phase entry, `dur` is latched as TEST_TIME if `test`=1, else the phase's *_TIME. WK always uses WALK_TIME; test does not shorten it.
- `test` changing mid-phase has no effect until the next entry.
- Elapsed counter: 0 on entry, +1 per tick. On the tick where elapsed==dur-1, the phase transitions and the new phase begins on the next cycle.
- `remaining` = dur − elapsed in timed phases, and 0 in YY.
- Pending: `pend[i]` sets on any cycle with `ped_req[i]`=1, except while state==WK, when requests are dropped.
- WK is chosen at an exit from YR or RY if `pend`≠0 in the register on the transition tick. A request asserted on that same tick cycle is latched but not counted; it waits for the next exit from YR or RY.
- WK entry: `ped_ack` = `pend` for one cycle, then `pend` is cleared. Both bits are served by one walk; there is no starvation.
- After WK, the ring resumes with the phase that would have followed the yellow (RG after YR, GR after RY).
- Lamps by state:
  - YY: lamp1=lamp2=010, walk=0
  - RY: lamp1=100, lamp2=010
  - GR: lamp1=001, lamp2=100
  - YR: lamp1=010, lamp2=100
  - RG: lamp1=100, lamp2=001
  - WK: lamp1=lamp2=100, walk=1
- Lamps are registered outputs decoded from the next state, so they change in the same cycle as `state`. A green and a green/yellow pair never coexist.
- Standby=1, sampled synchronously, on any cycle:
  - next cycle state=YY, elapsed=0, `pend`=0, no ack
  - overrides phase timing and pending requests
  - while held, YY is kept and `ped_req` is ignored
- An illegal state encoding recovers to YY on the next cycle.

## Timing
- Reset values: state=000, lamp1=lamp2=010, walk=0, ped_ack=00, remaining=0, tick=0, phase_start=0, div_cnt=0, pend=00, dur=0.
- Reset has priority over standby; standby has priority over timing.
- First tick after reset arrives at cycle TICK_DIV (div_cnt reaches TICK_DIV-1).
- Transition latency: the state change is visible 1 cycle after the terminating tick. `phase_start` and `ped_ack` are high in that same cycle.
- Phase length is exactly dur×TICK_DIV cycles, except the first phase after YY, which is aligned to the free-running divider.
- Request-to-ack latency is bounded by one full ring plus WK entry; a request is never lost outside WK and standby.

## Test plan
- Reset, then TICK_DIV=4, test=0, no requests, standby 1→0 → YY until the first tick, then RY(3)→GR(15)→YR(3)→RG(10)→RY. Each phase lasts dur×4 cycles, `remaining` counts 3,2,1, and `phase_start` pulses once per phase.
- ped_req=01 for 1 cycle during GR → after YR, WK for 8 ticks with walk=1, both lamps 100, ped_ack=01 for one cycle; then RG.
- ped_req=11 during RG, plus ped_req=10 pulsed during the following WK → ped_ack=11 at WK entry. The WK-time request is dropped and the next RY exit goes straight to GR.
- ped_req=10 asserted exactly on the YR terminating tick cycle with pend=0 → YR→RG (no WK); WK follows the next RY exit with ped_ack=10.
- test=1 raised mid-GR → GR keeps its latched 15; YR, RG and RY then last 2 ticks each; WK still lasts 8 ticks.
- Standby pulsed for 1 cycle mid-GR with pend=01 → next cycle YY, lamps 010/010, remaining=0, pend cleared; first tick afterwards enters RY. rst_n low mid-WK → reset values on the next cycle.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ==========================================================================
// traffic_phase_scheduler : two-road light sequencer with shared walk phase
// Revision: 1.0
// ==========================================================================
module traffic_phase_scheduler #(
    parameter int TICK_DIV  = 1000000,
    parameter int RG_TIME   = 10,
    parameter int RY_TIME   = 3,
    parameter int GR_TIME   = 15,
    parameter int YR_TIME   = 3,
    parameter int WALK_TIME = 8,
    parameter int TEST_TIME = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       standby,
    input  logic       test,
    input  logic [1:0] ped_req,
    output logic [1:0] ped_ack,
    output logic [2:0] state,
    output logic [2:0] lamp1,
    output logic [2:0] lamp2,
    output logic       walk,
    output logic [4:0] remaining,
    output logic       tick,
    output logic       phase_start
);

    localparam int DIV_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_YY = 3'b000,
        S_RY = 3'b001,
        S_GR = 3'b010,
        S_YR = 3'b011,
        S_RG = 3'b100,
        S_WK = 3'b101
    } state_t;

    state_t           state_q, state_d;
    state_t           resume_q, resume_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [4:0]       elapsed_q, elapsed_d;
    logic [4:0]       dur_q, dur_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       ped_ack_q, ped_ack_d;
    logic [2:0]       lamp1_q, lamp1_d;
    logic [2:0]       lamp2_q, lamp2_d;
    logic             walk_q, walk_d;
    logic             phase_start_q, phase_start_d;
    logic             w_tick;
    logic             w_phase_end;
    logic             w_enter;

    function automatic logic [4:0] phase_time(input state_t s);
        case (s)
            S_RY:    return 5'(RY_TIME);
            S_GR:    return 5'(GR_TIME);
            S_YR:    return 5'(YR_TIME);
            S_RG:    return 5'(RG_TIME);
            S_WK:    return 5'(WALK_TIME);
            default: return 5'd0;
        endcase
    endfunction

    // Lamp bits are {R,Y,G}; returns {lamp1, lamp2}.
    function automatic logic [5:0] lamps_for(input state_t s);
        case (s)
            S_RY:    return {3'b100, 3'b010};
            S_GR:    return {3'b001, 3'b100};
            S_YR:    return {3'b010, 3'b100};
            S_RG:    return {3'b100, 3'b001};
            S_WK:    return {3'b100, 3'b100};
            default: return {3'b010, 3'b010};
        endcase
    endfunction

    always_comb begin
        w_tick      = (div_cnt_q == DIV_W'(TICK_DIV - 1));
        div_cnt_d   = w_tick ? '0 : div_cnt_q + DIV_W'(1);
        w_phase_end = w_tick && (elapsed_q == dur_q - 5'd1);

        state_d  = state_q;
        resume_d = resume_q;
        case (state_q)
            S_YY: if (w_tick) state_d = S_RY;
            S_RY: begin
                if (w_phase_end) begin
                    if (pend_q != 2'b00) begin
                        state_d  = S_WK;
                        resume_d = S_GR;
                    end else begin
                        state_d  = S_GR;
                    end
                end
            end
            S_GR: if (w_phase_end) state_d = S_YR;
            S_YR: begin
                if (w_phase_end) begin
                    if (pend_q != 2'b00) begin
                        state_d  = S_WK;
                        resume_d = S_RG;
                    end else begin
                        state_d  = S_RG;
                    end
                end
            end
            S_RG: if (w_phase_end) state_d = S_RY;
            S_WK: if (w_phase_end) state_d = resume_q;
            default: state_d = S_YY;
        endcase
        if (standby) state_d = S_YY;

        w_enter = (state_d != state_q);

        if (standby || w_enter)
            elapsed_d = 5'd0;
        else if (w_tick && state_q != S_YY)
            elapsed_d = elapsed_q + 5'd1;
        else
            elapsed_d = elapsed_q;

        if (state_d == S_YY)
            dur_d = 5'd0;
        else if (w_enter)
            dur_d = (state_d == S_WK) ? 5'(WALK_TIME) :
                    (test ? 5'(TEST_TIME) : phase_time(state_d));
        else
            dur_d = dur_q;

        // A request arriving on the walk-entry cycle is kept for the next walk.
        ped_ack_d = 2'b00;
        if (standby) begin
            pend_d = 2'b00;
        end else if (w_enter && state_d == S_WK) begin
            ped_ack_d = pend_q;
            pend_d    = ped_req & ~pend_q;
        end else if (state_q == S_WK) begin
            pend_d = pend_q;
        end else begin
            pend_d = pend_q | ped_req;
        end

        phase_start_d      = w_enter && (state_d != S_YY);
        {lamp1_d, lamp2_d} = lamps_for(state_d);
        walk_d             = (state_d == S_WK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_YY;
            resume_q      <= S_RG;
            div_cnt_q     <= '0;
            elapsed_q     <= 5'd0;
            dur_q         <= 5'd0;
            pend_q        <= 2'b00;
            ped_ack_q     <= 2'b00;
            lamp1_q       <= 3'b010;
            lamp2_q       <= 3'b010;
            walk_q        <= 1'b0;
            phase_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            resume_q      <= resume_d;
            div_cnt_q     <= div_cnt_d;
            elapsed_q     <= elapsed_d;
            dur_q         <= dur_d;
            pend_q        <= pend_d;
            ped_ack_q     <= ped_ack_d;
            lamp1_q       <= lamp1_d;
            lamp2_q       <= lamp2_d;
            walk_q        <= walk_d;
            phase_start_q <= phase_start_d;
        end
    end

    assign state       = state_q;
    assign lamp1       = lamp1_q;
    assign lamp2       = lamp2_q;
    assign walk        = walk_q;
    assign ped_ack     = ped_ack_q;
    assign phase_start = phase_start_q;
    assign tick        = w_tick;
    assign remaining   = (state_q == S_YY) ? 5'd0 : dur_q - elapsed_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ==========================================================================
// tb_traffic_phase_scheduler : directed bench for traffic_phase_scheduler
// Revision: 1.0
// ==========================================================================
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       standby;
    logic       test;
    logic [1:0] ped_req;
    logic [1:0] ped_ack;
    logic [2:0] state;
    logic [2:0] lamp1;
    logic [2:0] lamp2;
    logic       walk;
    logic [4:0] remaining;
    logic       tick;
    logic       phase_start;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .TICK_DIV (4),
        .RG_TIME  (10),
        .RY_TIME  (3),
        .GR_TIME  (15),
        .YR_TIME  (3),
        .WALK_TIME(8),
        .TEST_TIME(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .standby    (standby),
        .test       (test),
        .ped_req    (ped_req),
        .ped_ack    (ped_ack),
        .state      (state),
        .lamp1      (lamp1),
        .lamp2      (lamp2),
        .walk       (walk),
        .remaining  (remaining),
        .tick       (tick),
        .phase_start(phase_start)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_ph(input string tag, input logic [2:0] st, input logic [2:0] l1,
                          input logic [2:0] l2, input logic w, input logic [4:0] rem);
        chk({tag, ".state"}, 8'(state), 8'(st));
        chk({tag, ".lamp1"}, 8'(lamp1), 8'(l1));
        chk({tag, ".lamp2"}, 8'(lamp2), 8'(l2));
        chk({tag, ".walk"}, 8'(walk), 8'(w));
        chk({tag, ".remaining"}, 8'(remaining), 8'(rem));
    endtask

    task automatic chk_reset(input string tag);
        chk_ph(tag, 3'd0, 3'b010, 3'b010, 1'b0, 5'd0);
        chk({tag, ".ped_ack"}, 8'(ped_ack), 8'd0);
        chk({tag, ".tick"}, 8'(tick), 8'd0);
        chk({tag, ".phase_start"}, 8'(phase_start), 8'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        standby = 1'b1;
        test    = 1'b0;
        ped_req = 2'b00;
        step();
        step();
        cyc = 0;
        chk_reset("reset");
        rst_n = 1'b1;

        // Normal ring without requests; tick on cycles 3,7,11,...
        goto(2);   standby = 1'b0;
        chk_ph("yy_hold", 3'd0, 3'b010, 3'b010, 1'b0, 5'd0);
        goto(3);   chk("first_tick", 8'(tick), 8'd1);
                   chk("yy_at_tick", 8'(state), 8'd0);
        goto(4);   chk_ph("ry_entry", 3'd1, 3'b100, 3'b010, 1'b0, 5'd3);
                   chk("ry_pstart", 8'(phase_start), 8'd1);
        goto(5);   chk("ry_pstart_low", 8'(phase_start), 8'd0);
                   chk("tick_low", 8'(tick), 8'd0);
        goto(8);   chk("ry_rem2", 8'(remaining), 8'd2);
        goto(12);  chk("ry_rem1", 8'(remaining), 8'd1);
        goto(15);  chk_ph("ry_last", 3'd1, 3'b100, 3'b010, 1'b0, 5'd1);
        goto(16);  chk_ph("gr_entry", 3'd2, 3'b001, 3'b100, 1'b0, 5'd15);
                   chk("gr_pstart", 8'(phase_start), 8'd1);
        goto(75);  chk_ph("gr_last", 3'd2, 3'b001, 3'b100, 1'b0, 5'd1);
        goto(76);  chk_ph("yr_entry", 3'd3, 3'b010, 3'b100, 1'b0, 5'd3);
        goto(88);  chk_ph("rg_entry", 3'd4, 3'b100, 3'b001, 1'b0, 5'd10);
        goto(127); chk_ph("rg_last", 3'd4, 3'b100, 3'b001, 1'b0, 5'd1);
        goto(128); chk_ph("ry2_entry", 3'd1, 3'b100, 3'b010, 1'b0, 5'd3);

        // Road-1 request during GR walks after YR
        goto(150); ped_req = 2'b01;
        step();    ped_req = 2'b00;
        goto(211); chk_ph("yr2_last", 3'd3, 3'b010, 3'b100, 1'b0, 5'd1);
        goto(212); chk_ph("wk1_entry", 3'd5, 3'b100, 3'b100, 1'b1, 5'd8);
                   chk("wk1_ack", 8'(ped_ack), 8'h01);
                   chk("wk1_pstart", 8'(phase_start), 8'd1);
        goto(213); chk("wk1_ack_pulse", 8'(ped_ack), 8'h00);
        goto(243); chk_ph("wk1_last", 3'd5, 3'b100, 3'b100, 1'b1, 5'd1);
        goto(244); chk_ph("wk1_to_rg", 3'd4, 3'b100, 3'b001, 1'b0, 5'd10);

        // Both roads request in RG; a request inside WK is dropped
        goto(250); ped_req = 2'b11;
        step();    ped_req = 2'b00;
        goto(296); chk_ph("wk2_entry", 3'd5, 3'b100, 3'b100, 1'b1, 5'd8);
                   chk("wk2_ack", 8'(ped_ack), 8'h03);
        goto(300); ped_req = 2'b10;
        step();    ped_req = 2'b00;
        goto(328); chk_ph("wk2_to_gr", 3'd2, 3'b001, 3'b100, 1'b0, 5'd15);
        goto(400); chk_ph("yr_no_wk", 3'd4, 3'b100, 3'b001, 1'b0, 5'd10);
        goto(452); chk_ph("ry_no_wk", 3'd2, 3'b001, 3'b100, 1'b0, 5'd15);

        // Request on the YR terminating tick is latched but not counted
        goto(523); ped_req = 2'b10;
                   chk("yr_term_tick", 8'(tick), 8'd1);
                   chk("yr_term_state", 8'(state), 8'd3);
        step();    ped_req = 2'b00;
        chk_ph("late_req_rg", 3'd4, 3'b100, 3'b001, 1'b0, 5'd10);
        chk("late_req_noack", 8'(ped_ack), 8'h00);
        goto(564); chk("late_ry", 8'(state), 8'd1);
        goto(576); chk_ph("wk3_entry", 3'd5, 3'b100, 3'b100, 1'b1, 5'd8);
                   chk("wk3_ack", 8'(ped_ack), 8'h02);

        // Test mode raised mid-GR
        goto(608); chk_ph("gr4_entry", 3'd2, 3'b001, 3'b100, 1'b0, 5'd15);
        goto(620); test = 1'b1;
        goto(630); ped_req = 2'b01;
        step();    ped_req = 2'b00;
        goto(667); chk_ph("gr4_latched", 3'd2, 3'b001, 3'b100, 1'b0, 5'd1);
        goto(668); chk_ph("yr_test", 3'd3, 3'b010, 3'b100, 1'b0, 5'd2);
        goto(675); chk_ph("yr_test_last", 3'd3, 3'b010, 3'b100, 1'b0, 5'd1);
        goto(676); chk_ph("wk_test", 3'd5, 3'b100, 3'b100, 1'b1, 5'd8);
                   chk("wk_test_ack", 8'(ped_ack), 8'h01);
        goto(707); chk_ph("wk_test_last", 3'd5, 3'b100, 3'b100, 1'b1, 5'd1);
        goto(708); chk_ph("rg_test", 3'd4, 3'b100, 3'b001, 1'b0, 5'd2);
        goto(716); chk_ph("ry_test", 3'd1, 3'b100, 3'b010, 1'b0, 5'd2);
        goto(724); chk_ph("gr_test", 3'd2, 3'b001, 3'b100, 1'b0, 5'd2);
        goto(725); test = 1'b0;
        goto(732); chk_ph("yr_normal", 3'd3, 3'b010, 3'b100, 1'b0, 5'd3);
        goto(744); chk_ph("rg_normal", 3'd4, 3'b100, 3'b001, 1'b0, 5'd10);
        goto(796); chk("gr6_entry", 8'(state), 8'd2);

        // One-cycle standby mid-GR with a pending request
        goto(800); ped_req = 2'b01;
        step();    ped_req = 2'b00;
        goto(810); standby = 1'b1;
        step();    standby = 1'b0;
        chk_ph("standby_yy", 3'd0, 3'b010, 3'b010, 1'b0, 5'd0);
        chk("standby_ack", 8'(ped_ack), 8'h00);
        chk("standby_tick", 8'(tick), 8'd1);
        goto(812); chk_ph("post_sb_ry", 3'd1, 3'b100, 3'b010, 1'b0, 5'd3);
        goto(824); chk_ph("pend_cleared", 3'd2, 3'b001, 3'b100, 1'b0, 5'd15);

        // Reset in the middle of a walk
        goto(830); ped_req = 2'b01;
        step();    ped_req = 2'b00;
        goto(896); chk("wk5_entry", 8'(state), 8'd5);
                   chk("wk5_ack", 8'(ped_ack), 8'h01);
        goto(900); rst_n = 1'b0;
        step();
        chk_reset("reset_mid_wk");
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
